// File: rtl/seq_hit_monitor.sv
// Window hit monitor for the 1010 sequence-detector output: windowed hit count, sticky alarm,
// saturating lifetime total. Optional min-gap tracking under `SEQ_HIT_MIN_GAP_EN`.
module seq_hit_monitor #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned THRESH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_vld,
  input  logic             hit,
  input  logic             clr,
  output logic             alarm,
  output logic             win_done,
  output logic [CNT_W-1:0] win_count,
  output logic [15:0]      total_hits,
  output logic             busy
`ifdef SEQ_HIT_MIN_GAP_EN
  ,
  output logic [CNT_W-1:0] min_gap
`endif
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCount = 2'b01,
    StAlarm = 2'b10
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] timer_q, hit_cnt_q;
  logic [CNT_W-1:0] timer_inc, hit_inc;
  logic             sample_hit;

  always_comb begin
    timer_inc  = timer_q + 1'b1;
    hit_inc    = hit_cnt_q + CNT_W'(hit);
    sample_hit = bit_vld & hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      hit_cnt_q  <= '0;
      alarm      <= 1'b0;
      win_done   <= 1'b0;
      win_count  <= '0;
      total_hits <= '0;
      busy       <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (sample_hit && (total_hits != 16'hFFFF)) begin
        total_hits <= total_hits + 16'd1;
      end
      if (clr) begin
        state_q   <= StIdle;
        timer_q   <= '0;
        hit_cnt_q <= '0;
        alarm     <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (sample_hit) begin
              state_q   <= StCount;
              timer_q   <= CNT_W'(1);
              hit_cnt_q <= CNT_W'(1);
              busy      <= 1'b1;
            end
          end
          StCount: begin
            if (bit_vld) begin
              // Threshold is checked first so a hit on the last sample alarms without win_done.
              if (hit_inc == CNT_W'(THRESH)) begin
                state_q   <= StAlarm;
                alarm     <= 1'b1;
                win_count <= CNT_W'(THRESH);
                busy      <= 1'b0;
                timer_q   <= '0;
                hit_cnt_q <= '0;
              end else if (timer_inc == CNT_W'(WIN_LEN)) begin
                state_q   <= StIdle;
                win_done  <= 1'b1;
                win_count <= hit_inc;
                busy      <= 1'b0;
                timer_q   <= '0;
                hit_cnt_q <= '0;
              end else begin
                timer_q   <= timer_inc;
                hit_cnt_q <= hit_inc;
              end
            end
          end
          StAlarm: begin
            alarm <= 1'b1;
            busy  <= 1'b0;
          end
          default: begin
            state_q   <= StIdle;
            timer_q   <= '0;
            hit_cnt_q <= '0;
            alarm     <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SEQ_HIT_MIN_GAP_EN
  logic [CNT_W-1:0] gap_q, gap_inc;
  logic             armed_q;

  // gap_inc is the distance in samples from the previous hit to the current sample.
  always_comb begin
    gap_inc = (&gap_q) ? gap_q : gap_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q   <= '0;
      armed_q <= 1'b0;
      min_gap <= '1;
    end else if (bit_vld) begin
      if (hit) begin
        if (armed_q && (gap_inc < min_gap)) begin
          min_gap <= gap_inc;
        end
        gap_q   <= '0;
        armed_q <= 1'b1;
      end else begin
        gap_q <= gap_inc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Self-checking bench for seq_hit_monitor: directed scenarios then random traffic, all compared
// cycle by cycle against a queue-based window model.
module tb_seq_hit_monitor;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned WIN_LEN = 16;
  localparam int unsigned THRESH  = 3;
  localparam int unsigned SAT     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             bit_vld = 1'b0;
  logic             hit = 1'b0;
  logic             clr = 1'b0;
  logic             alarm, win_done, busy;
  logic [CNT_W-1:0] win_count;
  logic [15:0]      total_hits;
`ifdef SEQ_HIT_MIN_GAP_EN
  logic [CNT_W-1:0] min_gap;
`endif

  seq_hit_monitor #(
    .CNT_W  (CNT_W),
    .WIN_LEN(WIN_LEN),
    .THRESH (THRESH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_vld   (bit_vld),
    .hit       (hit),
    .clr       (clr),
    .alarm     (alarm),
    .win_done  (win_done),
    .win_count (win_count),
    .total_hits(total_hits),
    .busy      (busy)
`ifdef SEQ_HIT_MIN_GAP_EN
    ,
    .min_gap   (min_gap)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the open window is the list of its sample hit bits.
  bit          win_q[$];
  bit          m_alarm, m_win_done;
  int unsigned m_win_count, m_total;
  int unsigned m_idx, m_last, m_min_gap;
  bit          m_have_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit v, input bit h, input bit c, input bit r);
    int n;
    if (r) begin
      win_q.delete();
      m_alarm = 0; m_win_done = 0; m_win_count = 0; m_total = 0;
      m_idx = 0; m_last = 0; m_have_last = 0; m_min_gap = SAT;
      return;
    end
    m_win_done = 0;
    if (v) begin
      m_idx++;
      if (h) begin
        if (m_have_last) begin
          n = (m_idx - m_last > SAT) ? SAT : m_idx - m_last;
          if (n < m_min_gap) m_min_gap = n;
        end
        m_have_last = 1;
        m_last = m_idx;
        if (m_total < 16'hFFFF) m_total++;
      end
    end
    if (c) begin
      win_q.delete();
      m_alarm = 0;
    end else if (!m_alarm && v) begin
      if (win_q.size() != 0 || h) begin
        win_q.push_back(h);
        n = 0;
        foreach (win_q[i]) n += win_q[i];
        if (n == THRESH) begin
          m_alarm = 1; m_win_count = THRESH; win_q.delete();
        end else if (win_q.size() == WIN_LEN) begin
          m_win_done = 1; m_win_count = n; win_q.delete();
        end
      end
    end
  endtask

  task automatic check_all();
    chk("alarm", 32'(alarm), 32'(m_alarm));
    chk("win_done", 32'(win_done), 32'(m_win_done));
    chk("win_count", 32'(win_count), m_win_count);
    chk("total_hits", 32'(total_hits), m_total);
    chk("busy", 32'(busy), 32'(win_q.size() != 0));
`ifdef SEQ_HIT_MIN_GAP_EN
    chk("min_gap", 32'(min_gap), m_min_gap);
`endif
  endtask

  task automatic step(input bit v, input bit h, input bit c, input bit r);
    bit_vld = v; hit = h; clr = c; rst = r;
    @(posedge clk);
    model(v, h, c, r);
    #1;
    check_all();
  endtask

  // Continuous samples 1..n with hits at the listed sample numbers (0 = unused).
  task automatic run(input int n, input int a, input int b, input int d);
    for (int s = 1; s <= n; s++) step(1, (s == a) || (s == b) || (s == d), 0, 0);
  endtask

  initial begin
    // Reset held two cycles with a qualified hit present.
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_total", 32'(total_hits), 0);
    chk("rst_busy", 32'(busy), 0);

    // Hits at 1,5,9 -> alarm.
    step(1, 1, 0, 0);
    chk("open_busy", 32'(busy), 1);
    run(8, 4, 8, 0);
    chk("thr_alarm", 32'(alarm), 1);
    chk("thr_count", 32'(win_count), THRESH);
    chk("thr_busy", 32'(busy), 0);
    chk("thr_total", 32'(total_hits), 3);
    run(2, 1, 2, 0);
    chk("alarm_total", 32'(total_hits), 5);
    chk("alarm_hold", 32'(alarm), 1);

    // clr with a hit in ALARM, then a new window.
    step(1, 1, 1, 0);
    chk("clr_alarm", 32'(alarm), 0);
    chk("clr_total", 32'(total_hits), 6);
    chk("clr_busy", 32'(busy), 0);
    step(1, 1, 0, 0);
    chk("reopen_busy", 32'(busy), 1);

    // That window: hits at 1 and 10 -> close after sample 16.
    run(15, 9, 0, 0);
    chk("close_done", 32'(win_done), 1);
    chk("close_count", 32'(win_count), 2);
    chk("close_alarm", 32'(alarm), 0);
    step(0, 0, 0, 0);
    chk("done_pulse", 32'(win_done), 0);

    // Hit only when not qualified.
    step(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(i % 2 == 0, i % 2 != 0, 0, 0);
    chk("unq_total", 32'(total_hits), 0);
    chk("unq_busy", 32'(busy), 0);

    // Reset mid-window.
    run(4, 1, 3, 0);
    step(1, 1, 0, 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_total", 32'(total_hits), 0);
    chk("mid_rst_count", 32'(win_count), 0);

    // Hits at 1,3,7.
    run(7, 1, 3, 7);
    chk("gap_alarm", 32'(alarm), 1);
`ifdef SEQ_HIT_MIN_GAP_EN
    chk("min_gap_2", 32'(min_gap), 2);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 40) == 0,
           ($urandom % 400) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
